// File: rtl/riscv151_csr_pkg.sv
// Shared CSR definitions for the Riscv151 CSR unit: address map and funct3 encodings.
package riscv151_csr_pkg;

  localparam logic [11:0] CSR_TOHOST   = 12'h51e;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic [2:0] {
    F3_RW  = 3'b001,
    F3_RS  = 3'b010,
    F3_RC  = 3'b011,
    F3_RWI = 3'b101,
    F3_RSI = 3'b110,
    F3_RCI = 3'b111
  } csr_funct3_e;

  // 000 and 100 carry no CSR operation.
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with enable and asynchronous active-high reset.
// The full-width add carries from the low word into the high word in the same edge.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [63:0] o_count
);

  logic [63:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_unit.sv
// CSR unit: decodes CSR instructions, owns tohost and the cycle/instret counters.
// csr_rdata is combinational from pre-edge state; writes and illegal_csr land one edge later.
module csr_unit
  import riscv151_csr_pkg::*;
#(
  parameter logic [31:0] RESET_TOHOST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic        stall,
  input  logic [2:0]  csr_funct3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  uimm,
  input  logic        inst_retire,
  output logic [31:0] csr_rdata,
  output logic [31:0] tohost,
  output logic        test_done,
  output logic        test_pass,
  output logic        illegal_csr
);

  logic [31:0] r_tohost;
  logic        r_illegal;

  logic [63:0] w_cycle;
  logic [63:0] w_instret;
  logic        w_retire;
  logic [31:0] w_src;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_mapped;
  logic        w_ro;
  logic        w_wr_intent;
  logic        w_illegal;
  logic        w_fire;
  logic        w_commit;

  assign w_retire = inst_retire & ~stall;

  csr_counter64 u_cycle (
    .clk     (clk),
    .rst     (rst),
    .i_en    (1'b1),
    .o_count (w_cycle)
  );

  csr_counter64 u_instret (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_retire),
    .o_count (w_instret)
  );

  assign w_src = csr_funct3[2] ? {27'b0, uimm} : rs1_data;

  always_comb begin
    w_mapped = 1'b1;
    w_ro     = 1'b1;
    w_old    = '0;
    case (csr_addr)
      CSR_TOHOST: begin
        w_ro  = 1'b0;
        w_old = r_tohost;
      end
      CSR_CYCLE:    w_old = w_cycle[31:0];
      CSR_CYCLEH:   w_old = w_cycle[63:32];
      CSR_INSTRET:  w_old = w_instret[31:0];
      CSR_INSTRETH: w_old = w_instret[63:32];
      default:      w_mapped = 1'b0;
    endcase
  end

  // Set/clear forms with a zero source index are pure reads; uimm carries the
  // rs1 index for register forms too.
  always_comb begin
    w_new       = w_src;
    w_wr_intent = 1'b0;
    case (csr_funct3)
      F3_RW, F3_RWI: begin
        w_new       = w_src;
        w_wr_intent = 1'b1;
      end
      F3_RS, F3_RSI: begin
        w_new       = w_old | w_src;
        w_wr_intent = (uimm != 5'd0);
      end
      F3_RC, F3_RCI: begin
        w_new       = w_old & ~w_src;
        w_wr_intent = (uimm != 5'd0);
      end
      default: begin
        w_new       = w_src;
        w_wr_intent = 1'b0;
      end
    endcase
  end

  assign w_illegal = ~f3_legal(csr_funct3) | ~w_mapped | (w_ro & w_wr_intent);
  assign w_fire    = csr_valid & ~stall;
  assign w_commit  = w_fire & w_wr_intent & ~w_illegal & (csr_addr == CSR_TOHOST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tohost  <= RESET_TOHOST;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_fire & w_illegal;
      if (w_commit) begin
        r_tohost <= w_new;
      end
    end
  end

  assign csr_rdata   = (csr_valid & ~w_illegal) ? w_old : 32'h0;
  assign tohost      = r_tohost;
  assign test_done   = r_tohost[0];
  assign test_pass   = (r_tohost == 32'h0000_0001);
  assign illegal_csr = r_illegal;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: scoreboarded tohost/rdata expectations, counter and reset scenarios.
module tb_csr_unit;
  import riscv151_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_valid = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  csr_funct3 = 3'b000;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] rs1_data = 32'h0;
  logic [4:0]  uimm = 5'd0;
  logic        inst_retire = 1'b0;
  logic [31:0] csr_rdata;
  logic [31:0] tohost;
  logic        test_done;
  logic        test_pass;
  logic        illegal_csr;

  int checks = 0;
  int failures = 0;
  logic [31:0] q_exp[$];
  logic [31:0] exp_v;
  longint unsigned m_cycle;
  longint unsigned m_instret;

  csr_unit #(.RESET_TOHOST(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_valid   (csr_valid),
    .stall       (stall),
    .csr_funct3  (csr_funct3),
    .csr_addr    (csr_addr),
    .rs1_data    (rs1_data),
    .uimm        (uimm),
    .inst_retire (inst_retire),
    .csr_rdata   (csr_rdata),
    .tohost      (tohost),
    .test_done   (test_done),
    .test_pass   (test_pass),
    .illegal_csr (illegal_csr)
  );

  always #5 clk = ~clk;

  // Reference counts of edges since reset and of unstalled retirements.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cycle   <= 0;
      m_instret <= 0;
    end else begin
      m_cycle <= m_cycle + 1;
      if (inst_retire && !stall) m_instret <= m_instret + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] r, input logic [4:0] u);
    csr_valid  = v;
    csr_funct3 = f3;
    csr_addr   = a;
    rs1_data   = r;
    uimm       = u;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, F3_RS, CSR_CYCLE, 32'h0, 5'd0);
    @(negedge clk); @(negedge clk);
    checks++; if (tohost !== 32'h0) begin failures++; $display("FAIL reset_tohost got=%h exp=%h", tohost, 32'h0); end
    checks++; if (test_done !== 1'b0 || test_pass !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", test_done, test_pass); end
    checks++; if (illegal_csr !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal_csr); end
    checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL reset_cycle got=%h exp=0", csr_rdata); end
    drive(1'b0, 3'b000, 12'h000, 32'h0, 5'd0);
    rst = 1'b0;
  endtask

  task automatic test_cycle_read;
    while (m_cycle < 100) @(negedge clk);
    drive(1'b1, F3_RS, CSR_CYCLE, 32'h0, 5'd0);
    q_exp.push_back(32'd100);
    #1;
    exp_v = q_exp.pop_front();
    checks++; if (csr_rdata !== exp_v) begin failures++; $display("FAIL cycle100 got=%0d exp=%0d", csr_rdata, exp_v); end
    csr_addr = CSR_CYCLEH;
    #1;
    checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL cycleh got=%h exp=0", csr_rdata); end
    @(posedge clk); #1;
    checks++; if (illegal_csr !== 1'b0) begin failures++; $display("FAIL cycle_read_illegal got=%b exp=0", illegal_csr); end
    @(negedge clk);
    drive(1'b0, 3'b000, 12'h000, 32'h0, 5'd0);
  endtask

  task automatic test_illegal;
    logic [2:0]  f3s [4] = '{F3_RW, F3_RS, 3'b000, 3'b100};
    logic [11:0] as  [4] = '{CSR_CYCLE, 12'h123, CSR_TOHOST, CSR_TOHOST};
    logic [31:0] th;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      th = tohost;
      drive(1'b1, f3s[i], as[i], 32'h0000_0055, 5'd3);
      #1;
      checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL illegal_rdata[%0d] got=%h exp=0", i, csr_rdata); end
      @(posedge clk); #1;
      checks++; if (illegal_csr !== 1'b1) begin failures++; $display("FAIL illegal_pulse[%0d] got=%b exp=1", i, illegal_csr); end
      @(negedge clk);
      drive(1'b0, 3'b000, 12'h000, 32'h0, 5'd0);
      @(posedge clk); #1;
      checks++; if (illegal_csr !== 1'b0) begin failures++; $display("FAIL illegal_width[%0d] got=%b exp=0", i, illegal_csr); end
      checks++; if (tohost !== th) begin failures++; $display("FAIL illegal_nowrite[%0d] got=%h exp=%h", i, tohost, th); end
    end
    @(negedge clk);
    drive(1'b1, F3_RSI, CSR_CYCLE, 32'h0, 5'd0);
    #1;
    checks++; if (csr_rdata !== m_cycle[31:0]) begin failures++; $display("FAIL cycle_after_illegal got=%0d exp=%0d", csr_rdata, m_cycle[31:0]); end
    @(posedge clk); #1;
    checks++; if (illegal_csr !== 1'b0) begin failures++; $display("FAIL rsi_zero_ro got=%b exp=0", illegal_csr); end
    @(negedge clk);
    drive(1'b0, 3'b000, 12'h000, 32'h0, 5'd0);
  endtask

  task automatic test_instret;
    @(negedge clk);
    inst_retire = 1'b1;
    repeat (10) @(negedge clk);
    stall = 1'b1;
    repeat (5) @(negedge clk);
    inst_retire = 1'b0;
    stall = 1'b0;
    drive(1'b1, F3_RS, CSR_INSTRET, 32'h0, 5'd0);
    #1;
    checks++; if (csr_rdata !== 32'd10) begin failures++; $display("FAIL instret got=%0d exp=10", csr_rdata); end
    checks++; if (csr_rdata !== m_instret[31:0]) begin failures++; $display("FAIL instret_model got=%0d exp=%0d", csr_rdata, m_instret[31:0]); end
    csr_addr = CSR_INSTRETH;
    #1;
    checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL instreth got=%h exp=0", csr_rdata); end
    @(negedge clk);
    drive(1'b0, 3'b000, 12'h000, 32'h0, 5'd0);
  endtask

  task automatic test_tohost_write;
    @(negedge clk);
    drive(1'b1, F3_RWI, CSR_TOHOST, 32'h0, 5'd1);
    q_exp.push_back(32'h0);
    q_exp.push_back(32'h1);
    #1;
    exp_v = q_exp.pop_front();
    checks++; if (csr_rdata !== exp_v) begin failures++; $display("FAIL csrwi_old got=%h exp=%h", csr_rdata, exp_v); end
    @(posedge clk); #1;
    exp_v = q_exp.pop_front();
    checks++; if (tohost !== exp_v) begin failures++; $display("FAIL csrwi_tohost got=%h exp=%h", tohost, exp_v); end
    checks++; if (test_done !== 1'b1 || test_pass !== 1'b1) begin failures++; $display("FAIL csrwi_flags got=%b%b exp=11", test_done, test_pass); end
    @(negedge clk);
    drive(1'b1, F3_RW, CSR_TOHOST, 32'h0000_000B, 5'd7);
    q_exp.push_back(32'hB);
    @(posedge clk); #1;
    exp_v = q_exp.pop_front();
    checks++; if (tohost !== exp_v) begin failures++; $display("FAIL csrw_tohost got=%h exp=%h", tohost, exp_v); end
    checks++; if (test_done !== 1'b1 || test_pass !== 1'b0) begin failures++; $display("FAIL csrw_flags got=%b%b exp=10", test_done, test_pass); end
    @(negedge clk);
    drive(1'b0, 3'b000, 12'h000, 32'h0, 5'd0);
  endtask

  task automatic test_stall_and_setclear;
    @(negedge clk);
    stall = 1'b1;
    drive(1'b1, F3_RW, CSR_TOHOST, 32'h0000_0003, 5'd9);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (csr_rdata !== 32'hB) begin failures++; $display("FAIL stall_rdata[%0d] got=%h exp=b", i, csr_rdata); end
      @(posedge clk); #1;
      checks++; if (tohost !== 32'hB) begin failures++; $display("FAIL stall_hold[%0d] got=%h exp=b", i, tohost); end
      @(negedge clk);
    end
    stall = 1'b0;
    q_exp.push_back(32'h3);
    @(posedge clk); #1;
    exp_v = q_exp.pop_front();
    checks++; if (tohost !== exp_v) begin failures++; $display("FAIL stall_release got=%h exp=%h", tohost, exp_v); end
    // Back-to-back set then clear: the clear must observe the set result.
    @(negedge clk);
    drive(1'b1, F3_RSI, CSR_TOHOST, 32'h0, 5'd4);
    q_exp.push_back(32'h3);
    q_exp.push_back(32'h7);
    #1;
    exp_v = q_exp.pop_front();
    checks++; if (csr_rdata !== exp_v) begin failures++; $display("FAIL rsi_old got=%h exp=%h", csr_rdata, exp_v); end
    @(posedge clk); #1;
    exp_v = q_exp.pop_front();
    checks++; if (tohost !== exp_v) begin failures++; $display("FAIL rsi_tohost got=%h exp=%h", tohost, exp_v); end
    @(negedge clk);
    drive(1'b1, F3_RCI, CSR_TOHOST, 32'h0, 5'd1);
    q_exp.push_back(32'h7);
    q_exp.push_back(32'h6);
    #1;
    exp_v = q_exp.pop_front();
    checks++; if (csr_rdata !== exp_v) begin failures++; $display("FAIL rci_old got=%h exp=%h", csr_rdata, exp_v); end
    @(posedge clk); #1;
    exp_v = q_exp.pop_front();
    checks++; if (tohost !== exp_v) begin failures++; $display("FAIL rci_tohost got=%h exp=%h", tohost, exp_v); end
    @(negedge clk);
    drive(1'b1, F3_RS, CSR_TOHOST, 32'hFFFF_FFFF, 5'd0);
    @(posedge clk); #1;
    checks++; if (tohost !== 32'h6) begin failures++; $display("FAIL rs_x0_nowrite got=%h exp=6", tohost); end
    @(negedge clk);
    drive(1'b0, 3'b000, 12'h000, 32'h0, 5'd0);
  endtask

  task automatic test_carry;
    @(negedge clk);
    force dut.u_cycle.r_count = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.u_cycle.r_count;
    @(posedge clk); #1;
    drive(1'b1, F3_RS, CSR_CYCLE, 32'h0, 5'd0);
    #1;
    checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL carry_low got=%h exp=0", csr_rdata); end
    csr_addr = CSR_CYCLEH;
    #1;
    checks++; if (csr_rdata !== 32'h1) begin failures++; $display("FAIL carry_high got=%h exp=1", csr_rdata); end
    @(negedge clk);
    drive(1'b0, 3'b000, 12'h000, 32'h0, 5'd0);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    drive(1'b1, 3'b000, CSR_TOHOST, 32'h0, 5'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (tohost !== 32'h0) begin failures++; $display("FAIL arst_tohost got=%h exp=0", tohost); end
    checks++; if (test_done !== 1'b0 || test_pass !== 1'b0) begin failures++; $display("FAIL arst_flags got=%b%b exp=00", test_done, test_pass); end
    checks++; if (illegal_csr !== 1'b0) begin failures++; $display("FAIL arst_illegal got=%b exp=0", illegal_csr); end
    drive(1'b1, F3_RS, CSR_CYCLEH, 32'h0, 5'd0);
    #1;
    checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL arst_cycleh got=%h exp=0", csr_rdata); end
    csr_addr = CSR_INSTRET;
    #1;
    checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL arst_instret got=%h exp=0", csr_rdata); end
    drive(1'b1, F3_RWI, CSR_TOHOST, 32'h0, 5'd5);
    @(posedge clk); #1;
    checks++; if (tohost !== 32'h0) begin failures++; $display("FAIL arst_discard got=%h exp=0", tohost); end
    @(negedge clk);
    drive(1'b0, 3'b000, 12'h000, 32'h0, 5'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (tohost !== 32'h0) begin failures++; $display("FAIL post_reset_tohost got=%h exp=0", tohost); end
  endtask

  initial begin
    test_reset();
    test_cycle_read();
    test_illegal();
    test_instret();
    test_tohost_write();
    test_stall_and_setclear();
    test_carry();
    test_async_reset();
    checks++; if (q_exp.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", q_exp.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
